fetch_seq: RTL
==============

# fetch_seq

Instruction-fetch sequencer for the core front end. It owns the program counter and issues single-outstanding requests to instruction memory. Each returned word is presented downstream with a valid/ready handshake. It applies PC redirects from the execute-stage branch resolution logic: taken branches, jumps and the branch unit's resolved PC. On a redirect it discards any stale fetch and raises a one-cycle flush to the decode stage.

## Interface
- RESET_VEC, 32'h0000_0000, PC loaded on reset
- TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned redirect
- clk  in  1  single core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (word aligned)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; at least 1 cycle after gnt
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr/instr_pc valid to decode
- instr  out  32  fetched instruction
- instr_pc  out  32  address of instr
- instr_ready  in  1  decode accepts instr
- redirect  in  1  execute stage requests new PC this cycle
- redirect_pc  in  32  redirect target
- flush  out  1  one-cycle pulse: decode must drop its contents
- misalign  out  1  one-cycle pulse: redirect_pc[1:0] != 0

## Operation
- States: IDLE, REQ, WAIT, HOLD. Internal regs: pc, pc_inflight, kill.
- rst=1: state=IDLE, pc=RESET_VEC, kill=0. All outputs are 0 (instr, instr_pc, imem_addr = 0).
- IDLE -> REQ unconditionally.
- REQ: imem_req=1, imem_addr=pc.
  - gnt -> WAIT, pc_inflight=pc.
  - Otherwise stay in REQ with the address held stable.
- WAIT: imem_req=0.
  - rvalid with kill=0: capture instr=imem_rdata and instr_pc=pc_inflight, set pc=pc+4, go to HOLD.
  - rvalid with kill=1: discard the data, clear kill, go to REQ.
- HOLD: instr_valid=1 with instr/instr_pc stable until instr_ready. On ready -> REQ.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC increments to 0. No error on wrap.
- Redirect has priority over all normal transitions; only rst outranks it.
  - New pc = redirect_pc, or TRAP_VEC with misalign pulsed if redirect_pc[1:0] != 0.
  - flush=1 for exactly the next cycle.
  - instr_valid=0 from the next cycle.
- Redirect per state:
  - IDLE: go to REQ with the new pc.
  - REQ without same-cycle gnt: stay in REQ. The request is withdrawn and reissued at the new pc next cycle.
  - REQ with same-cycle gnt: go to WAIT with kill=1.
  - WAIT without same-cycle rvalid: kill=1, stay in WAIT.
  - WAIT with same-cycle rvalid: drop the data, kill=0, go to REQ.
  - HOLD: drop instr, ignore instr_ready, go to REQ.
- A second redirect while kill=1 just updates pc. Only one response is ever discarded.
- rst mid-operation aborts everything. A late rvalid after reset with state not WAIT is ignored.

## Timing
- Reset released at cycle 0: imem_req=1, imem_addr=RESET_VEC at cycle 1.
- Steady state with gnt immediate, rvalid 1 cycle later and ready=1: REQ→WAIT→HOLD. That is 3 cycles per instruction, instr_valid high 1 of 3.
- instr_valid rises the cycle after rvalid. It falls the cycle after ready or redirect.
- Redirect in cycle N with nothing in flight: imem_req at the new pc in cycle N+1, flush=1 in N+1.
- Redirect in WAIT: new request 1 cycle after the stale rvalid.
- All outputs are registered except imem_req/imem_addr, which decode state and pc.

## Structure
- Package fetch_pkg holds:
  - fetch_state_t enum (IDLE, REQ, WAIT, HOLD)
  - INSTR_BYTES = 4
  - the word-alignment mask constant
- Single module with no sub-module. The FSM, pc register and capture registers sit in one always_ff, with next-state/outputs in one always_comb.

## Test plan
- Reset, gnt=1 always, rvalid 1 cycle after gnt, ready=1 -> instr_pc sequence 0x0, 0x4, 0x8, one instruction per 3 cycles.
- Hold instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, no new imem_req until ready.
- Redirect to 0x200 while in WAIT with rvalid delayed 3 cycles -> stale word dropped, flush pulse, next imem_addr=0x200, next instr_pc=0x200.
- Redirect to 0x123 -> misalign pulse, next imem_addr=TRAP_VEC (0x100).
- pc=0xFFFF_FFFC fetched -> next imem_addr=0x0000_0000.
- Assert rst in WAIT, then late rvalid -> output ignored, first request at RESET_VEC, instr_valid stays 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    // Fetch FSM states. The encodings are fixed so that state dumps stay readable.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Size of one instruction word, used for the sequential PC step.
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // A PC is word aligned when it has no bits set outside this mask.
    localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer. It owns the PC and issues one outstanding
// request at a time to instruction memory. Each returned word is presented
// to decode with a valid/ready handshake. Execute-stage redirects replace the
// PC, discard any stale response and pulse flush (and misalign for an
// unaligned target, which is sent to TRAP_VEC instead).
module fetch_seq
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        flush,
    output logic        misalign
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pc_inflight_q, pc_inflight_d;
    logic         kill_q, kill_d;
    logic         capture;
    logic         misaligned;
    logic [31:0]  redirect_target;

    // Next-state, next-PC and memory request decode. A redirect is applied
    // last so that it overrides whatever the normal transition chose.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d         = state_q;
        pc_d            = pc_q;
        pc_inflight_d   = pc_inflight_q;
        kill_d          = kill_q;
        capture         = 1'b0;
        misaligned      = |(redirect_pc & ~ALIGN_MASK);
        redirect_target = misaligned ? TRAP_VEC : redirect_pc;
        imem_req        = (state_q == REQ);
        imem_addr       = (state_q == REQ) ? pc_q : 32'h0;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_d       = WAIT;
                    pc_inflight_d = pc_q;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q) begin
                        // This is the response of a fetch that a redirect made
                        // stale: drop it and fetch from the new PC.
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        capture = 1'b1;
                        pc_d    = pc_q + INSTR_BYTES;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (instr_ready) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            pc_d    = redirect_target;
            capture = 1'b0;
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    // A request granted this cycle is already in flight, so
                    // its response must be discarded later.
                    if (imem_gnt) begin
                        state_d = WAIT;
                        kill_d  = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d = REQ;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = WAIT;
                        kill_d  = 1'b1;
                    end
                end
                HOLD:    state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, PC, capture registers and the registered pulse outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VEC;
            pc_inflight_q <= 32'h0;
            kill_q        <= 1'b0;
            instr         <= 32'h0;
            instr_pc      <= 32'h0;
            instr_valid   <= 1'b0;
            flush         <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_inflight_q <= pc_inflight_d;
            kill_q        <= kill_d;
            instr_valid   <= (state_d == HOLD);
            flush         <= redirect;
            misalign      <= redirect & misaligned;
            if (capture) begin
                instr    <= imem_rdata;
                instr_pc <= pc_inflight_q;
            end
        end
    end

endmodule
